// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/mem/commit sequencer for the comproc core.
// Owns the shared memory port handshake, commit gating and interrupt entry.
module exec_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ack,
    input  logic        irq,
    input  logic        ie_set,
    input  logic        dec_rd_mem,
    input  logic        dec_wr_mem,
    input  logic        dec_pop,
    input  logic        dec_push,
    input  logic        dec_load_stk,
    input  logic        dec_load_fp,
    input  logic        dec_load_ip,
    input  logic        dec_cpop,
    input  logic        dec_cpush,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_load,
    output logic        ir_inject,
    output logic        ip_inc,
    output logic        en_pop,
    output logic        en_push,
    output logic        en_stk,
    output logic        en_fp,
    output logic        en_ip,
    output logic        en_cpop,
    output logic        en_cpush,
    output logic        irq_ack,
    output logic        ie,
    output logic [1:0]  phase,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        INTR,
        DECODE,
        MEM,
        EXEC
    } state_t;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ie      <= 1'b0;
            retired <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state == EXEC) begin
                retired <= retired + 16'd1;
                if (ie_set) begin
                    ie <= 1'b1;
                end
            end else if (state == INTR) begin
                ie <= 1'b0;
            end
        end
    end

    // Strobes are suppressed while rst is high so an in-flight
    // request or commit cannot leak out during the reset cycle.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_load   = 1'b0;
        ir_inject = 1'b0;
        ip_inc    = 1'b0;
        en_pop    = 1'b0;
        en_push   = 1'b0;
        en_stk    = 1'b0;
        en_fp     = 1'b0;
        en_ip     = 1'b0;
        en_cpop   = 1'b0;
        en_cpush  = 1'b0;
        irq_ack   = 1'b0;
        phase     = 2'd0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    state_nxt = FETCH;
                end
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_load   = 1'b1;
                        ip_inc    = 1'b1;
                        state_nxt = DECODE;
                    end
                end
                DECODE: begin
                    phase = 2'd1;
                    if (dec_rd_mem || dec_wr_mem) begin
                        state_nxt = MEM;
                    end else begin
                        state_nxt = EXEC;
                    end
                end
                MEM: begin
                    phase    = 2'd2;
                    mem_req  = 1'b1;
                    mem_we   = dec_wr_mem;
                    addr_sel = 1'b1;
                    if (mem_ack) begin
                        state_nxt = EXEC;
                    end
                end
                EXEC: begin
                    phase    = 2'd3;
                    en_pop   = dec_pop;
                    en_push  = dec_push;
                    en_stk   = dec_load_stk;
                    en_fp    = dec_load_fp;
                    en_ip    = dec_load_ip;
                    en_cpop  = dec_cpop;
                    en_cpush = dec_cpush;
                    if (irq && ie) begin
                        state_nxt = INTR;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
                INTR: begin
                    ir_load   = 1'b1;
                    ir_inject = 1'b1;
                    irq_ack   = 1'b1;
                    state_nxt = DECODE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: per-cycle stimulus and expected
// outputs are queued per scenario, then replayed and compared.
module tb_exec_sequencer;

    logic        clk;
    logic        rst;
    logic        mem_ack;
    logic        irq;
    logic        ie_set;
    logic        dec_rd_mem;
    logic        dec_wr_mem;
    logic        dec_pop;
    logic        dec_push;
    logic        dec_load_stk;
    logic        dec_load_fp;
    logic        dec_load_ip;
    logic        dec_cpop;
    logic        dec_cpush;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_load;
    logic        ir_inject;
    logic        ip_inc;
    logic        en_pop;
    logic        en_push;
    logic        en_stk;
    logic        en_fp;
    logic        en_ip;
    logic        en_cpop;
    logic        en_cpush;
    logic        irq_ack;
    logic        ie;
    logic [1:0]  phase;
    logic [15:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    exec_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .mem_ack      (mem_ack),
        .irq          (irq),
        .ie_set       (ie_set),
        .dec_rd_mem   (dec_rd_mem),
        .dec_wr_mem   (dec_wr_mem),
        .dec_pop      (dec_pop),
        .dec_push     (dec_push),
        .dec_load_stk (dec_load_stk),
        .dec_load_fp  (dec_load_fp),
        .dec_load_ip  (dec_load_ip),
        .dec_cpop     (dec_cpop),
        .dec_cpush    (dec_cpush),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .addr_sel     (addr_sel),
        .ir_load      (ir_load),
        .ir_inject    (ir_inject),
        .ip_inc       (ip_inc),
        .en_pop       (en_pop),
        .en_push      (en_push),
        .en_stk       (en_stk),
        .en_fp        (en_fp),
        .en_ip        (en_ip),
        .en_cpop      (en_cpop),
        .en_cpush     (en_cpush),
        .irq_ack      (irq_ack),
        .ie           (ie),
        .phase        (phase),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_req, mem_we, addr_sel, ir_load, ir_inject, ip_inc}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_FW   = 6'b100000;
    localparam logic [5:0] C_FA   = 6'b100101;
    localparam logic [5:0] C_MR   = 6'b101000;
    localparam logic [5:0] C_MW   = 6'b111000;
    localparam logic [5:0] C_IN   = 6'b000110;

    wire [32:0] obs = {mem_req, mem_we, addr_sel, ir_load, ir_inject,
                       ip_inc, en_pop, en_push, en_stk, en_fp, en_ip,
                       en_cpop, en_cpush, irq_ack, ie, phase, retired};

    typedef struct {
        logic [12:0] stim;
        logic [32:0] exp;
    } step_t;

    step_t sb[$];

    function automatic logic [32:0] ex(input logic [5:0] c,
                                       input logic [6:0] en,
                                       input logic ak, input logic iev,
                                       input logic [1:0] ph,
                                       input logic [15:0] r);
        return {c, en, ak, iev, ph, r};
    endfunction

    // en / dec vector order: {pop, push, stk, fp, ip, cpop, cpush}
    task automatic push(input logic rs, input logic ak, input logic iq,
                        input logic ies, input logic rd, input logic wr,
                        input logic [6:0] dc, input logic [32:0] e);
        step_t s;
        s.stim = {rs, ak, iq, ies, rd, wr, dc};
        s.exp  = e;
        sb.push_back(s);
    endtask

    task automatic apply(input logic [12:0] v);
        {rst, mem_ack, irq, ie_set, dec_rd_mem, dec_wr_mem,
         dec_pop, dec_push, dec_load_stk, dec_load_fp,
         dec_load_ip, dec_cpop, dec_cpush} = v;
    endtask

    task automatic test_reset();
        step_t s;
        int cyc = 0;
        for (int i = 0; i < 3; i++)
            push(1, 1, 1, 1, 1, 1, 7'h7f, ex(C_NONE, 0, 0, 0, 0, 0));
        push(0, 0, 0, 0, 0, 0, 0, ex(C_NONE, 0, 0, 0, 0, 0));
        push(0, 0, 0, 0, 0, 0, 0, ex(C_FW, 0, 0, 0, 0, 0));
        while (sb.size() != 0) begin
            s = sb.pop_front();
            apply(s.stim);
            #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL reset cyc%0d got %h want %h", cyc, obs, s.exp);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_alu();
        step_t s;
        int cyc = 0;
        logic [6:0] d = 7'b1010000;
        push(0, 1, 0, 0, 0, 0, d, ex(C_FA, 0, 0, 0, 0, 0));
        push(0, 0, 0, 0, 0, 0, d, ex(C_NONE, 0, 0, 0, 1, 0));
        push(0, 0, 0, 0, 0, 0, d, ex(C_NONE, d, 0, 0, 3, 0));
        push(0, 0, 0, 0, 0, 0, d, ex(C_FW, 0, 0, 0, 0, 1));
        while (sb.size() != 0) begin
            s = sb.pop_front();
            apply(s.stim);
            #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL alu cyc%0d got %h want %h", cyc, obs, s.exp);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_load();
        step_t s;
        int cyc = 0;
        logic [6:0] d = 7'b0010000;
        push(0, 1, 0, 0, 1, 0, d, ex(C_FA, 0, 0, 0, 0, 1));
        push(0, 1, 0, 0, 1, 0, d, ex(C_NONE, 0, 0, 0, 1, 1));
        push(0, 0, 0, 0, 1, 0, d, ex(C_MR, 0, 0, 0, 2, 1));
        push(0, 0, 0, 0, 1, 0, d, ex(C_MR, 0, 0, 0, 2, 1));
        push(0, 1, 0, 0, 1, 0, d, ex(C_MR, 0, 0, 0, 2, 1));
        push(0, 1, 0, 0, 1, 0, d, ex(C_NONE, d, 0, 0, 3, 1));
        push(0, 0, 0, 0, 0, 0, 0, ex(C_FW, 0, 0, 0, 0, 2));
        while (sb.size() != 0) begin
            s = sb.pop_front();
            apply(s.stim);
            #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL load cyc%0d got %h want %h", cyc, obs, s.exp);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_store();
        step_t s;
        int cyc = 0;
        logic [6:0] d  = 7'b0100000;
        logic [6:0] d2 = 7'b0000010;
        push(0, 0, 0, 0, 0, 1, d, ex(C_FW, 0, 0, 0, 0, 2));
        push(0, 1, 0, 0, 0, 1, d, ex(C_FA, 0, 0, 0, 0, 2));
        push(0, 0, 0, 0, 0, 1, d, ex(C_NONE, 0, 0, 0, 1, 2));
        push(0, 1, 0, 0, 0, 1, d, ex(C_MW, 0, 0, 0, 2, 2));
        push(0, 0, 0, 0, 0, 1, d, ex(C_NONE, d, 0, 0, 3, 2));
        push(0, 1, 0, 0, 1, 1, d2, ex(C_FA, 0, 0, 0, 0, 3));
        push(0, 0, 0, 0, 1, 1, d2, ex(C_NONE, 0, 0, 0, 1, 3));
        push(0, 0, 0, 0, 1, 1, d2, ex(C_MW, 0, 0, 0, 2, 3));
        push(0, 1, 0, 0, 1, 1, d2, ex(C_MW, 0, 0, 0, 2, 3));
        push(0, 0, 0, 0, 1, 1, d2, ex(C_NONE, d2, 0, 0, 3, 3));
        push(0, 0, 0, 0, 0, 0, 0, ex(C_FW, 0, 0, 0, 0, 4));
        while (sb.size() != 0) begin
            s = sb.pop_front();
            apply(s.stim);
            #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL store cyc%0d got %h want %h", cyc, obs, s.exp);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_interrupt();
        step_t s;
        int cyc = 0;
        logic [6:0] d  = 7'b0000100;
        logic [6:0] di = 7'b0100100;
        push(0, 1, 1, 1, 0, 0, d, ex(C_FA, 0, 0, 0, 0, 4));
        push(0, 0, 1, 1, 0, 0, d, ex(C_NONE, 0, 0, 0, 1, 4));
        push(0, 0, 1, 0, 0, 0, d, ex(C_NONE, d, 0, 0, 3, 4));
        push(0, 1, 1, 0, 0, 0, d, ex(C_FA, 0, 0, 0, 0, 5));
        push(0, 0, 1, 0, 0, 0, d, ex(C_NONE, 0, 0, 0, 1, 5));
        push(0, 0, 1, 1, 0, 0, d, ex(C_NONE, d, 0, 0, 3, 5));
        push(0, 1, 1, 0, 0, 0, d, ex(C_FA, 0, 0, 1, 0, 6));
        push(0, 0, 1, 0, 0, 0, d, ex(C_NONE, 0, 0, 1, 1, 6));
        push(0, 0, 1, 0, 0, 0, d, ex(C_NONE, d, 0, 1, 3, 6));
        push(0, 1, 1, 0, 0, 0, 0, ex(C_IN, 0, 1, 1, 0, 7));
        push(0, 0, 1, 0, 0, 0, di, ex(C_NONE, 0, 0, 0, 1, 7));
        push(0, 0, 1, 0, 0, 0, di, ex(C_NONE, di, 0, 0, 3, 7));
        push(0, 0, 0, 0, 0, 0, 0, ex(C_FW, 0, 0, 0, 0, 8));
        while (sb.size() != 0) begin
            s = sb.pop_front();
            apply(s.stim);
            #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL intr cyc%0d got %h want %h", cyc, obs, s.exp);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_irq_drop();
        step_t s;
        int cyc = 0;
        logic [6:0] d = 7'b0001000;
        push(0, 1, 0, 0, 0, 0, d, ex(C_FA, 0, 0, 0, 0, 8));
        push(0, 0, 0, 0, 0, 0, d, ex(C_NONE, 0, 0, 0, 1, 8));
        push(0, 0, 0, 1, 0, 0, d, ex(C_NONE, d, 0, 0, 3, 8));
        push(0, 1, 1, 0, 0, 0, d, ex(C_FA, 0, 0, 1, 0, 9));
        push(0, 0, 1, 0, 0, 0, d, ex(C_NONE, 0, 0, 1, 1, 9));
        push(0, 0, 0, 0, 0, 0, d, ex(C_NONE, d, 0, 1, 3, 9));
        push(0, 0, 1, 0, 0, 0, 0, ex(C_FW, 0, 0, 1, 0, 10));
        while (sb.size() != 0) begin
            s = sb.pop_front();
            apply(s.stim);
            #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL irqdrop cyc%0d got %h want %h", cyc, obs, s.exp);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mem();
        step_t s;
        int cyc = 0;
        logic [6:0] d = 7'b1111111;
        push(0, 1, 0, 0, 1, 0, d, ex(C_FA, 0, 0, 1, 0, 10));
        push(0, 0, 0, 0, 1, 0, d, ex(C_NONE, 0, 0, 1, 1, 10));
        push(0, 0, 0, 0, 1, 0, d, ex(C_MR, 0, 0, 1, 2, 10));
        push(1, 1, 0, 0, 1, 0, d, ex(C_NONE, 0, 0, 1, 0, 10));
        push(0, 1, 0, 0, 1, 0, d, ex(C_NONE, 0, 0, 0, 0, 0));
        push(0, 0, 0, 0, 1, 0, d, ex(C_FW, 0, 0, 0, 0, 0));
        while (sb.size() != 0) begin
            s = sb.pop_front();
            apply(s.stim);
            #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL rstmem cyc%0d got %h want %h", cyc, obs, s.exp);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        step_t s;
        int cyc = 0;
        logic [6:0] d = 7'b0000001;
        apply(13'd0);
        force dut.retired = 16'hfffe;
        @(negedge clk);
        release dut.retired;
        push(0, 0, 0, 0, 0, 0, d, ex(C_FW, 0, 0, 0, 0, 16'hfffe));
        push(0, 1, 0, 0, 0, 0, d, ex(C_FA, 0, 0, 0, 0, 16'hfffe));
        push(0, 0, 0, 0, 0, 0, d, ex(C_NONE, 0, 0, 0, 1, 16'hfffe));
        push(0, 0, 0, 0, 0, 0, d, ex(C_NONE, d, 0, 0, 3, 16'hfffe));
        push(0, 1, 0, 0, 0, 0, d, ex(C_FA, 0, 0, 0, 0, 16'hffff));
        push(0, 0, 0, 0, 0, 0, d, ex(C_NONE, 0, 0, 0, 1, 16'hffff));
        push(0, 0, 0, 0, 0, 0, d, ex(C_NONE, d, 0, 0, 3, 16'hffff));
        push(0, 0, 0, 0, 0, 0, 0, ex(C_FW, 0, 0, 0, 0, 16'h0000));
        while (sb.size() != 0) begin
            s = sb.pop_front();
            apply(s.stim);
            #1;
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL wrap cyc%0d got %h want %h", cyc, obs, s.exp);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        apply({1'b1, 12'd0});
        @(negedge clk);
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_interrupt();
        test_irq_drop();
        test_reset_mem();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle control sequencer for the comproc CPU core. Each instruction passes through fetch, decode, optional memory access and commit phases. The block drives a single shared memory port for instruction and data traffic using a req/ack handshake. It gates the datapath register-load strobes produced by the instruction decoder so they fire exactly once, in the commit cycle, and it injects the INT instruction when an enabled interrupt is pending at an instruction boundary.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- mem_ack  in  1  memory port completion; sampled only while mem_req=1.
- irq  in  1  level interrupt request.
- ie_set  in  1  decoded "enable interrupts"; honoured only in EXEC.
- dec_rd_mem, dec_wr_mem  in  1 each  decoder memory-access flags.
- dec_pop, dec_push, dec_load_stk, dec_load_fp, dec_load_ip, dec_cpop, dec_cpush  in  1 each  decoder commit flags.
- mem_req  out  1  memory port request.
- mem_we  out  1  write enable; meaningful while mem_req=1.
- addr_sel  out  1  0 = address from IP, 1 = address from ALU result.
- ir_load  out  1  load instruction register this edge.
- ir_inject  out  1  IR source is constant 16'h7810 (INT) instead of memory data.
- ip_inc  out  1  increment IP by 2 this edge.
- en_pop, en_push, en_stk, en_fp, en_ip, en_cpop, en_cpush  out  1 each  gated commit strobes.
- irq_ack  out  1  one-cycle interrupt acknowledge.
- ie  out  1  interrupt-enable flag.
- phase  out  2  0 = IDLE/FETCH, 1 = DECODE, 2 = MEM, 3 = EXEC; for debug.
- retired  out  16  count of committed instructions.

## Operation
- States: IDLE, FETCH, INTR, DECODE, MEM, EXEC. All outputs are decoded combinationally from the state and the inputs. Registered state: state, ie, retired.
- IDLE: all strobes 0. Moves to FETCH on the next edge.
- FETCH: mem_req=1, mem_we=0, addr_sel=0. When mem_ack=1: ir_load=1, ip_inc=1, next state DECODE. When mem_ack=0: stay; mem_req remains high.
- DECODE: single cycle, no strobes. If dec_rd_mem|dec_wr_mem, go to MEM; otherwise go to EXEC. If both flags are 1, treat the access as a write.
- MEM: mem_req=1, mem_we=dec_wr_mem, addr_sel=1. Wait for mem_ack, then go to EXEC. The datapath captures read data at the ack edge.
- EXEC: single cycle. Each en_x equals the matching dec_x. retired increments and wraps from 16'hffff to 0. If ie_set=1, ie becomes 1 at this edge. Next state is INTR if irq&ie, using the value of ie registered before this edge; otherwise FETCH.
- INTR: ir_load=1, ir_inject=1, irq_ack=1, ip_inc=0. ie clears at this edge. Next state DECODE. The injected instruction then runs through DECODE and EXEC normally.
- ie_set outside EXEC is ignored. An instruction that sets ie therefore shadows interrupts for one further instruction.
- Only one memory transaction is outstanding at a time. mem_ack outside FETCH/MEM is ignored.

## Timing
- While rst=1 and on the cycle after: state=IDLE, ie=0, retired=0, and every output is 0 (phase=0).
- The first mem_req rises in the second cycle after rst falls.
- With zero-wait memory (ack in the same cycle as req): non-memory instruction = 3 cycles (FETCH, DECODE, EXEC); memory instruction = 4 cycles.
- Each wait cycle extends FETCH or MEM by one cycle. mem_we and addr_sel are stable for the whole request.
- Interrupt entry adds INTR + DECODE + EXEC = 3 cycles and no fetch.
- Commit strobes and retired update occur only in EXEC, exactly once per instruction.
- rst asserted in any state, including MEM with mem_req=1: the next cycle is IDLE, no commit strobes fire, a pending ack is discarded, ie=0 and retired=0.
- irq deasserted before EXEC samples it: no entry and no irq_ack.

## Test plan
- Reset: hold rst 3 cycles then release. All outputs are 0 through the first post-reset cycle; mem_req=1, addr_sel=0 in the next cycle.
- Zero-wait ALU instruction (dec_load_stk=1, dec_pop=1): FETCH, DECODE, EXEC in 3 cycles. en_stk and en_pop each pulse exactly 1 cycle; retired goes 0 to 1.
- Load with data ack delayed 2 cycles: MEM lasts 3 cycles with mem_req=1, mem_we=0, addr_sel=1. EXEC follows; instruction takes 6 cycles total.
- Store (dec_wr_mem=1): mem_we=1 only in MEM, never in FETCH.
- Interrupt: irq=1 with ie=0 gives no entry. Next, EXEC with ie_set=1 (irq still high): one more full instruction retires, then INTR with ir_inject=1, irq_ack=1; ie=0 afterwards.
- rst during MEM while awaiting ack: no en_* strobe fires; next cycle IDLE; retired=0.
- Wrap: preload via 65536 instructions; retired goes 16'hffff to 0.
